com_tx_unit: RTL and testbench

- Responder side of the COM instruction. When the PC control unit raises its sticky COM flag, this block dumps a fixed window of data memory to the host interpreter over a UART line, then reports completion.
- Sits beside the vector CPU core. It takes the COM flag as its start input, owns a read-only port into data memory, and drives the external tx pin.

---
 rtl/com_pkg.sv | 19 +
 rtl/uart_tx_byte.sv | 64 ++++++
 rtl/com_tx_unit.sv | 109 ++++++++++
 tb/tb_com_tx_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
// Shared types and constants for the COM responder: FSM states, the sync byte
// that opens every dump, and the shape of one UART frame.
package com_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_FETCH,
      S_WAIT,
      S_SEND,
      S_NEXT,
      S_DONE
   } com_state_t;

   localparam logic [7:0] HEADER_BYTE = 8'hA5;
   localparam int         DATA_BITS   = 8;
   localparam int         STOP_BITS   = 1;

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte 8N1 serializer: a load starts the start bit on the next cycle, and
// done_pulse is high during the final cycle of the stop bit.
module uart_tx_byte
   import com_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done_pulse
);

   localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
   localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS + STOP_BITS);

   logic [BW-1:0] baud;
   logic [3:0]    bit_idx;
   logic [7:0]    shreg;
   logic          active;

   // bit_idx 0 is the start bit, 1..8 the data bits, 9 the stop bit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         baud       <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         active     <= 1'b0;
         tx         <= 1'b1;
         done_pulse <= 1'b0;
      end else if (load) begin
         baud       <= '0;
         bit_idx    <= '0;
         shreg      <= data;
         active     <= 1'b1;
         tx         <= 1'b0;
         done_pulse <= 1'b0;
      end else if (active) begin
         done_pulse <= (bit_idx == LAST_BIT) && (baud == BAUD_PRE);
         if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == LAST_BIT) begin
               active <= 1'b0;
               tx     <= 1'b1;
            end else if (bit_idx == LAST_BIT - 4'd1) begin
               tx <= 1'b1;
            end else begin
               tx    <= shreg[0];
               shreg <= {1'b0, shreg[7:1]};
            end
         end else begin
            baud <= baud + 1'b1;
         end
      end else begin
         done_pulse <= 1'b0;
      end
   end

endmodule

// File: rtl/com_tx_unit.sv
// COM responder: on a rising edge of the sticky COM flag, sends the sync byte
// followed by LEN bytes of data memory over UART, then raises a sticky done.
module com_tx_unit
   import com_pkg::*;
#(
   parameter int          I            = 32,
   parameter int          N            = 8,
   parameter int unsigned BASE_ADDR    = 0,
   parameter int          LEN          = 16,
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [7:0]  HEADER       = HEADER_BYTE
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         com_start,
   output logic [I-1:0] mem_addr,
   input  logic [N-1:0] mem_rdata,
   output logic         tx,
   output logic         busy,
   output logic         done
);

   localparam logic [I-1:0] BASE = I'(BASE_ADDR);
   localparam logic [7:0]   LEN8 = 8'(LEN);

   com_state_t state;
   logic       com_start_q;
   logic       start_edge;
   logic [7:0] index;
   logic [7:0] index_nxt;
   logic       load;
   logic       byte_done;
   logic [7:0] byte_data;

   assign start_edge = com_start & ~com_start_q;
   assign index_nxt  = index + 8'd1;
   // load is high in the first HDR cycle or in WAIT, when mem_rdata is valid.
   assign byte_data  = (state == S_HDR) ? HEADER : mem_rdata[7:0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         com_start_q <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         index       <= '0;
         mem_addr    <= BASE;
         load        <= 1'b0;
      end else begin
         com_start_q <= com_start;
         load        <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start_edge) begin
                  state <= S_HDR;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  index <= '0;
                  load  <= 1'b1;
               end
            end
            S_HDR: begin
               if (byte_done) begin
                  if (LEN == 0) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     mem_addr <= BASE;
                     state    <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               load  <= 1'b1;
               state <= S_WAIT;
            end
            S_WAIT: state <= S_SEND;
            S_SEND: begin
               if (byte_done) state <= S_NEXT;
            end
            S_NEXT: begin
               index <= index_nxt;
               if (index_nxt == LEN8) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  mem_addr <= BASE + I'(index_nxt);
                  state    <= S_FETCH;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .data      (byte_data),
      .tx        (tx),
      .done_pulse(byte_done)
   );

endmodule

// File: tb/tb_com_tx_unit.sv
// Bench for com_tx_unit: three instances (payload window, empty window,
// wrapping 4-bit address) decoded from tx samples against a byte-stream model.
module tb_com_tx_unit;

   localparam int CB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
   logic [31:0] addr0, addr1;
   logic [3:0]  addr2;
   logic [7:0]  rdata0 = '0, rdata1 = '0, rdata2 = '0;
   logic        tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;

   logic [7:0]  mem0 [0:255];
   logic [7:0]  mem2 [0:15];

   int cfg_len  [3] = '{3, 0, 2};
   int cfg_base [3] = '{8, 8, 15};
   int cfg_iw   [3] = '{32, 32, 4};

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   com_tx_unit #(.I(32), .N(8), .BASE_ADDR(8), .LEN(3), .CLKS_PER_BIT(CB), .HEADER(8'hA5)) dut0 (
      .clk(clk), .reset(reset), .com_start(start0), .mem_addr(addr0),
      .mem_rdata(rdata0), .tx(tx0), .busy(busy0), .done(done0));

   com_tx_unit #(.I(32), .N(8), .BASE_ADDR(8), .LEN(0), .CLKS_PER_BIT(CB), .HEADER(8'hA5)) dut1 (
      .clk(clk), .reset(reset), .com_start(start1), .mem_addr(addr1),
      .mem_rdata(rdata1), .tx(tx1), .busy(busy1), .done(done1));

   com_tx_unit #(.I(4), .N(8), .BASE_ADDR(15), .LEN(2), .CLKS_PER_BIT(CB), .HEADER(8'hA5)) dut2 (
      .clk(clk), .reset(reset), .com_start(start2), .mem_addr(addr2),
      .mem_rdata(rdata2), .tx(tx2), .busy(busy2), .done(done2));

   // Synchronous-read memories: data valid one cycle after the address.
   always @(posedge clk) begin
      rdata0 <= mem0[addr0[7:0]];
      rdata1 <= mem0[addr1[7:0]];
      rdata2 <= mem2[addr2];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic get_tx(input int id);
      case (id)
         0: return tx0;
         1: return tx1;
         default: return tx2;
      endcase
   endfunction

   function automatic logic get_busy(input int id);
      case (id)
         0: return busy0;
         1: return busy1;
         default: return busy2;
      endcase
   endfunction

   function automatic logic get_done(input int id);
      case (id)
         0: return done0;
         1: return done1;
         default: return done2;
      endcase
   endfunction

   function automatic int get_addr(input int id);
      case (id)
         0: return int'(addr0);
         1: return int'(addr1);
         default: return int'(addr2);
      endcase
   endfunction

   task automatic set_start(input int id, input logic v);
      case (id)
         0: start0 = v;
         1: start1 = v;
         default: start2 = v;
      endcase
   endtask

   function automatic int model_addr(input int id, input int k);
      longint unsigned span;
      span = longint'(1) << cfg_iw[id];
      return int'((longint'(cfg_base[id]) + longint'(k)) % span);
   endfunction

   function automatic logic [7:0] model_byte(input int id, input int a);
      if (id == 2) return mem2[a % 16];
      return mem0[a % 256];
   endfunction

   // Run one transfer on instance id, optionally pulsing com_start mid-way.
   task automatic xfer(input int id, input bit pulse_mid);
      logic       q[$];
      logic       bq[$];
      int         aq[$];
      int         starts[$];
      logic [7:0] got_q[$];
      logic [7:0] exp_q[$];
      int         exp_addr[$];
      int         len, total, budget, done_at, pulse_at, idx, bad, exp_start;
      logic [9:0] cells;
      len     = cfg_len[id];
      total   = (len + 1) * 10 * CB + 3 * len + 1;
      budget  = total + 10 * CB + 20;
      done_at = -1;
      exp_q.push_back(8'hA5);
      for (int k = 0; k < len; k++) begin
         exp_addr.push_back(model_addr(id, k));
         exp_q.push_back(model_byte(id, model_addr(id, k)));
      end
      pulse_at = pulse_mid ? int'($urandom_range(20, total - 20)) : -10;

      @(negedge clk);
      set_start(id, 1'b1);
      @(posedge clk);
      #1;
      check("busy_after_edge", get_busy(id), 1);
      check("done_cleared", get_done(id), 0);
      for (int k = 0; k < budget; k++) begin
         q.push_back(get_tx(id));
         bq.push_back(get_busy(id));
         aq.push_back(get_addr(id));
         if (done_at < 0 && get_done(id) === 1'b1) done_at = k;
         if (k == pulse_at) set_start(id, 1'b0);
         if (k == pulse_at + 2) set_start(id, 1'b1);
         @(posedge clk);
         #1;
      end

      check("done_cycle", done_at, total);
      if (done_at > 0) begin
         check("busy_at_done", bq[done_at], 0);
         check("busy_before_done", bq[done_at - 1], 1);
      end

      idx = 0;
      while (idx < q.size()) begin
         if (q[idx] === 1'b0 && idx + 10 * CB <= q.size()) begin
            bad = 0;
            for (int b = 0; b < 10; b++) begin
               cells[b] = q[idx + b * CB];
               for (int j = 1; j < CB; j++)
                  if (q[idx + b * CB + j] !== cells[b]) bad++;
            end
            if (cells[9] !== 1'b1) bad++;
            check("frame_shape", bad, 0);
            got_q.push_back(cells[8:1]);
            starts.push_back(idx);
            idx += 10 * CB;
         end else begin
            idx++;
         end
      end

      check("byte_count", got_q.size(), exp_q.size());
      exp_start = 1;
      for (int b = 0; b < got_q.size() && b < exp_q.size(); b++) begin
         if (b == 1) exp_start = 1 + 10 * CB + 2;
         else if (b > 1) exp_start = exp_start + 10 * CB + 3;
         check("byte_value", got_q[b], exp_q[b]);
         check("frame_start", starts[b], exp_start);
      end
      for (int k = 0; k < len; k++)
         if (k + 1 < starts.size()) check("mem_addr", aq[starts[k + 1]], exp_addr[k]);
      if (len == 0) begin
         bad = 0;
         foreach (aq[k]) if (aq[k] != cfg_base[id]) bad++;
         check("addr_stable", bad, 0);
      end
   endtask

   task automatic hold_quiet(input int id, input int cycles);
      int bad;
      bad = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         #1;
         if (get_tx(id) !== 1'b1 || get_done(id) !== 1'b1) bad++;
      end
      check("sticky_quiet", bad, 0);
   endtask

   task automatic drop(input int id);
      @(negedge clk);
      set_start(id, 1'b0);
      repeat (3) @(posedge clk);
   endtask

   task automatic load_basic_mem();
      for (int a = 0; a < 256; a++) mem0[a] = 8'($urandom);
      for (int a = 0; a < 16; a++) mem2[a] = 8'($urandom);
      mem0[8]  = 8'h11;
      mem0[9]  = 8'h80;
      mem0[10] = 8'hFF;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      load_basic_mem();
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx0", tx0, 1);
      check("rst_tx1", tx1, 1);
      check("rst_tx2", tx2, 1);
      check("rst_busy0", busy0, 0);
      check("rst_done0", done0, 0);
      check("rst_busy2", busy2, 0);
      check("rst_done2", done2, 0);
      check("rst_addr0", addr0, 8);
      check("rst_addr2", addr2, 15);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_tx0", tx0, 1);
      check("idle_busy0", busy0, 0);

      xfer(0, 1'b0);
      hold_quiet(0, 500);
      drop(0);
      xfer(0, 1'b1);
      drop(0);
      xfer(1, 1'b0);
      hold_quiet(1, 50);
      drop(1);
      xfer(2, 1'b0);
      drop(2);

      for (int r = 0; r < 4; r++) begin
         for (int a = 8; a <= 10; a++) mem0[a] = 8'($urandom);
         for (int a = 0; a < 16; a++) mem2[a] = 8'($urandom);
         xfer(0, r[0]);
         drop(0);
         xfer(2, 1'b1);
         drop(2);
      end

      // Reset during data bit 3 of the 0x80 byte (third frame).
      load_basic_mem();
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 103; k++) @(posedge clk);
      #1;
      check("tx_mid_frame", tx0, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_tx", tx0, 1);
      check("mid_rst_busy", busy0, 0);
      check("mid_rst_done", done0, 0);
      start0 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      bad = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1;
         if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
      end
      check("no_recovery_byte", bad, 0);
      xfer(0, 1'b0);
      drop(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
